// File: rtl/dmem_if.sv
// Load/store port between the core's data-memory initiator and dmem_responder.
// Request and response each use their own valid/ready handshake.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Core side: issues requests and consumes responses.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Memory side: accepts requests and produces responses.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, WAIT_CYCLES wait states,
// word-organised RAM with byte enables, misalignment/range error flag.
// Optional feature macro: DMEM_MMIO_EN adds an R/W output register at
// 0xFFFF_0000 (driven on mmio_out) and a read-only cycle counter at 0xFFFF_0004.
// Timing: request accepted at edge N is decoded at edge N+WAIT_CYCLES+1, which
// is also the edge rsp_valid rises on.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    dmem_if.slave       bus,
    output logic [31:0] mmio_out
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          decode_now;
    logic          misaligned;
    logic          out_of_range;
    logic          hit_mmio_reg;
    logic          hit_mmio_cnt;
    logic [AW-1:0] word_idx;
    logic          ram_wr;
    logic [31:0]   mmio_rdata;

    // Address decode of the captured request; MMIO words take priority over range.
    always_comb begin
        word_idx     = addr_q[AW+1:2];
        misaligned   = (addr_q[1:0] != 2'b00);
        out_of_range = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
`ifdef DMEM_MMIO_EN
        hit_mmio_reg = (addr_q == 32'hFFFF_0000);
        hit_mmio_cnt = (addr_q == 32'hFFFF_0004);
`else
        hit_mmio_reg = 1'b0;
        hit_mmio_cnt = 1'b0;
`endif
        // The decode edge is the last WAIT cycle, once the counter has run out.
        decode_now   = (state_q == S_WAIT) && (cnt_q == 4'd0);
        ram_wr       = decode_now && we_q && !hit_mmio_reg && !hit_mmio_cnt
                       && !misaligned && !out_of_range;
    end

    // Next-state and handshake outputs for IDLE -> WAIT -> RESP -> IDLE.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (hit_mmio_reg || hit_mmio_cnt) begin
                        if (!we_q) rdata_d = mmio_rdata;
                    end else if (misaligned || out_of_range) begin
                        err_d = 1'b1;
                    end else if (!we_q) begin
                        rdata_d = mem[word_idx];
                    end
                end
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    // rdata deliberately holds past the handshake; err does not.
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and captured-request registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte-masked RAM write, a single edge so a store is all-or-nothing.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array has no reset; ram_wr is gated by state_q, which reset forces to IDLE.
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_q, mmio_d;
    logic [31:0] cyc_q, cyc_d;

    // MMIO register honours byte enables; the cycle counter ignores stores.
    always_comb begin
        mmio_d = mmio_q;
        if (decode_now && we_q && hit_mmio_reg) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mmio_d[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
        cyc_d = cyc_q + 32'd1;
    end

    // MMIO register and free-running cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mmio_q <= '0;
            cyc_q  <= '0;
        end else begin
            mmio_q <= mmio_d;
            cyc_q  <= cyc_d;
        end
    end

    assign mmio_out   = mmio_q;
    assign mmio_rdata = hit_mmio_reg ? mmio_q : cyc_q;
`else
    assign mmio_out   = '0;
    assign mmio_rdata = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// reset/backpressure/MMIO sequences, and random traffic against a word-array model.
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int WAITS = 2;
    localparam int LAT   = WAITS + 1;
    localparam int NWIN  = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mmio_out;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    dmem_if bus();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mmio_out (mmio_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [15];
    logic [31:0] ref_mem [NWIN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction; called #1 after an edge, returns #1 after the handshake edge.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output int lat, output int acc_cyc);
        int k = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        while (!bus.req_ready && k < 50) begin
            tick();
            k++;
        end
        check("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
        tick();
        acc_cyc = cyc;
        // Scribble over the request lines: only the accept edge may matter.
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_be    = 4'($urandom);
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    // Reference: memory as an array of words, addressed by byte address / 4.
    function automatic void model_access(input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [3:0] be,
                                         output logic [31:0] rdata, output logic err);
        longint unsigned word = longint'(addr) / 4;
        rdata = '0;
        err   = (addr % 4 != 0) || (word >= DEPTH);
        if (err) return;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[word][8*b +: 8] = wdata[8*b +: 8];
            end
        end else begin
            rdata = ref_mem[word];
        end
    endfunction

    initial begin
        logic [31:0] rd, rd2, exp_rd, held;
        logic        er, exp_er;
        int          lat, acc, acc2;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        #1;
        check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_mmio_out", mmio_out, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Directed vectors: store/load, byte enables, errors, boundaries
        vecs[0]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0040, 32'h1122_3344, 4'h5, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0,         4'hF, 32'hDE22_BE44, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0041, 32'h0,         4'hF, 32'h0, 1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0BAD_F00D, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'hF, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 32'h1234_5678, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_0042, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
        vecs[13] = '{1'b0, 32'h0000_0040, 32'h0,         4'hF, 32'hDE22_BE44, 1'b0};
        vecs[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 32'h0, 1'b1};
        for (int i = 0; i < 15; i++) begin
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat, acc);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
        end

        // MMIO window
`ifdef DMEM_MMIO_EN
        do_txn(1'b1, 32'hFFFF_0000, 32'h0000_00A5, 4'h1, rd, er, lat, acc);
        check("mmio_store_err", {31'd0, er}, 32'd0);
        check("mmio_out", mmio_out, 32'h0000_00A5);
        do_txn(1'b1, 32'hFFFF_0000, 32'h1234_5600, 4'h2, rd, er, lat, acc);
        check("mmio_out_be", mmio_out, 32'h0000_56A5);
        do_txn(1'b0, 32'hFFFF_0000, 32'h0, 4'hF, rd, er, lat, acc);
        check("mmio_load", rd, 32'h0000_56A5);
        do_txn(1'b0, 32'hFFFF_0004, 32'h0, 4'hF, rd, er, lat, acc);
        repeat ($urandom_range(1, 7)) tick();
        do_txn(1'b0, 32'hFFFF_0004, 32'h0, 4'hF, rd2, er, lat, acc2);
        check("cycle_counter_delta", rd2 - rd, 32'(acc2 - acc));
        do_txn(1'b1, 32'hFFFF_0004, 32'hFFFF_FFFF, 4'hF, rd, er, lat, acc);
        check("counter_store_err", {31'd0, er}, 32'd0);
`else
        do_txn(1'b1, 32'hFFFF_0000, 32'h0000_00A5, 4'h1, rd, er, lat, acc);
        check("mmio_off_store_err", {31'd0, er}, 32'd1);
        check("mmio_off_out", mmio_out, 32'd0);
        do_txn(1'b0, 32'hFFFF_0004, 32'h0, 4'hF, rd, er, lat, acc);
        check("mmio_off_load_err", {31'd0, er}, 32'd1);
        check("mmio_off_load_rdata", rd, 32'd0);
`endif

        // Reset in the middle of a store's wait states
        do_txn(1'b1, 32'h0000_0010, 32'h55AA_55AA, 4'hF, rd, er, lat, acc);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0000_0010;
        bus.req_wdata = 32'hFFFF_FFFF;
        bus.req_be    = 4'hF;
        tick();
        bus.req_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("t1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("t1_mmio_out", mmio_out, 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("t1_req_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (4) tick();
        check("t1_no_response", {31'd0, bus.rsp_valid}, 32'd0);
        do_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, rd, er, lat, acc);
        check("t1_word_unchanged", rd, 32'h55AA_55AA);

        // Response backpressure with a competing request held on the bus
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_0040;
        bus.req_be    = 4'hF;
        tick();
        bus.req_we    = 1'b1;
        bus.req_wdata = 32'h0F0F_0F0F;
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("t5_latency", 32'(lat), 32'(LAT));
        held = bus.rsp_rdata;
        check("t5_rdata", held, 32'hDE22_BE44);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("t5_hold%0d_valid", c), {31'd0, bus.rsp_valid}, 32'd1);
            check($sformatf("t5_hold%0d_rdata", c), bus.rsp_rdata, 32'hDE22_BE44);
            check($sformatf("t5_hold%0d_req_ready", c), {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("t5_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
        check("t5_err_low", {31'd0, bus.rsp_err}, 32'd0);
        check("t5_rdata_holds", bus.rsp_rdata, 32'hDE22_BE44);
        check("t5_ready_back", {31'd0, bus.req_ready}, 32'd1);
        tick();
        check("t5_accepted", {31'd0, bus.req_ready}, 32'd0);
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("t5_store_latency", 32'(lat), 32'(LAT));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        do_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, rd, er, lat, acc);
        check("t5_store_landed", rd, 32'h0F0F_0F0F);

        // Random traffic against the reference model
        for (int w = 0; w < NWIN; w++) begin
            logic [31:0] v = $urandom;
            model_access(1'b1, 32'(w * 4), v, 4'hF, exp_rd, exp_er);
            do_txn(1'b1, 32'(w * 4), v, 4'hF, rd, er, lat, acc);
            check("rand_init_err", {31'd0, er}, 32'd0);
        end
        for (int i = 0; i < 150; i++) begin
            int          sel = $urandom_range(0, 9);
            logic        we = 1'($urandom);
            logic [3:0]  be = 4'($urandom);
            logic [31:0] wd = $urandom;
            logic [31:0] ad;
            if (sel < 7)      ad = 32'($urandom_range(0, NWIN - 1) * 4);
            else if (sel < 8) ad = 32'($urandom_range(0, NWIN - 1) * 4 + $urandom_range(1, 3));
            else              ad = 32'(DEPTH * 4 + $urandom_range(0, 255) * 4);
            model_access(we, ad, wd, be, exp_rd, exp_er);
            do_txn(we, ad, wd, be, rd, er, lat, acc);
            check($sformatf("rand%0d_rdata@%h", i, ad), rd, exp_rd);
            check($sformatf("rand%0d_err@%h", i, ad), {31'd0, er}, {31'd0, exp_er});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the stimulus process is wedged somewhere unexpected.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
